// File: rtl/calib_seq.sv
// calib_seq: calibration trigger sequencer for NCH channels.
// Synchronised requests start single or burst shots with delayed LCT/L1A.
module calib_seq #(
  parameter int NCH = 2,
  parameter int DW  = 12,
  parameter int PW  = 7,
  parameter int BW  = 8
) (
  input  logic           CLKCMS,
  input  logic           RST_N,
  input  logic           EN,
  input  logic [NCH-1:0] TRIG_EXT,
  input  logic [NCH-1:0] TRIG_CCB,
  input  logic           FPED,
  input  logic           RNDMGTRG,
  input  logic [PW-1:0]  PLS_WIDTH,
  input  logic [DW-1:0]  LCT_DLY,
  input  logic [DW-1:0]  L1A_DLY,
  input  logic [BW-1:0]  BURST_CNT,
  input  logic [DW-1:0]  BURST_GAP,
  output logic [NCH-1:0] PULSE,
  output logic           SYNCIP,
  output logic           CALLCT,
  output logic           CAL_GTRG,
  output logic           PEDESTAL,
  output logic           BUSY,
  output logic           SEQ_DONE,
  output logic [7:0]     DROP_CNT
);

  typedef enum logic [1:0] {
    IDLE,
    SHOT,
    GAP,
    DONE
  } state_t;

  state_t         r_state;
  state_t         w_nstate;
  logic [DW-1:0]  r_tcnt;
  logic [DW-1:0]  w_ntcnt;
  logic [BW-1:0]  r_shots;
  logic [BW-1:0]  w_nshots;

  logic [NCH-1:0] r_mask;
  logic [PW-1:0]  r_width;
  logic [DW-1:0]  r_lct;
  logic [DW-1:0]  r_l1a;
  logic [DW-1:0]  r_gap;
  logic [DW-1:0]  r_tend;

  logic [NCH-1:0] r_ext_s1;
  logic [NCH-1:0] r_ext_s2;
  logic [NCH-1:0] r_ext_d;
  logic           r_fped_s1;
  logic           r_fped_s2;
  logic           r_fped_d;

  logic [NCH-1:0] w_req_mask;
  logic           w_req;
  logic           w_fped_edge;
  logic           w_ped_rise;
  logic           w_abort;
  logic           w_accept;
  logic [PW-1:0]  w_width_in;
  logic [BW-1:0]  w_shots_in;
  logic [DW-1:0]  w_tend;

  logic [NCH-1:0] w_pulse;
  logic           w_sync;
  logic           w_lct;
  logic           w_l1a;
  logic           w_done;

  assign w_req_mask  = (r_ext_s2 & ~r_ext_d) | TRIG_CCB;
  assign w_req       = |w_req_mask;
  assign w_fped_edge = r_fped_s2 & ~r_fped_d;
  assign w_ped_rise  = w_fped_edge & ~PEDESTAL;
  assign w_abort     = (r_state != IDLE) & (~EN | w_ped_rise);
  assign w_accept    = (r_state == IDLE) & w_req & EN &
                       ~PEDESTAL & ~w_ped_rise;

  assign w_width_in = (PLS_WIDTH == '0) ? PW'(1) : PLS_WIDTH;
  assign w_shots_in = (BURST_CNT == '0) ? BW'(1) : BURST_CNT;

  // shot length is fixed at accept time: last tcnt of the shot
  always_comb begin
    w_tend = DW'(w_width_in) - DW'(1);
    if (LCT_DLY > w_tend) w_tend = LCT_DLY;
    if (L1A_DLY > w_tend) w_tend = L1A_DLY;
  end

  always_comb begin
    w_nstate = r_state;
    w_ntcnt  = r_tcnt;
    w_nshots = r_shots;
    w_pulse  = '0;
    w_sync   = 1'b0;
    w_lct    = 1'b0;
    w_l1a    = 1'b0;
    w_done   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_nstate = SHOT;
          w_ntcnt  = '0;
          w_nshots = w_shots_in;
        end
      end
      SHOT: begin
        w_pulse = (r_tcnt < DW'(r_width)) ? r_mask : '0;
        w_sync  = (r_tcnt == '0);
        w_lct   = (r_tcnt == r_lct);
        w_l1a   = (r_tcnt == r_l1a);
        w_ntcnt = r_tcnt + DW'(1);
        if (r_tcnt == r_tend) begin
          w_ntcnt = '0;
          if (r_shots > BW'(1)) begin
            w_nshots = r_shots - BW'(1);
            w_nstate = (r_gap == '0) ? SHOT : GAP;
          end else begin
            w_nstate = DONE;
          end
        end
      end
      GAP: begin
        w_ntcnt = r_tcnt + DW'(1);
        if (r_tcnt == r_gap - DW'(1)) begin
          w_nstate = SHOT;
          w_ntcnt  = '0;
        end
      end
      DONE: begin
        w_done   = 1'b1;
        w_nstate = IDLE;
      end
      default: w_nstate = IDLE;
    endcase
    if (w_abort) begin
      w_nstate = IDLE;
      w_ntcnt  = '0;
      w_pulse  = '0;
      w_sync   = 1'b0;
      w_lct    = 1'b0;
      w_l1a    = 1'b0;
      w_done   = 1'b0;
    end
  end

  always_ff @(posedge CLKCMS or negedge RST_N) begin
    if (!RST_N) begin
      r_state   <= IDLE;
      r_tcnt    <= '0;
      r_shots   <= '0;
      r_mask    <= '0;
      r_width   <= '0;
      r_lct     <= '0;
      r_l1a     <= '0;
      r_gap     <= '0;
      r_tend    <= '0;
      r_ext_s1  <= '0;
      r_ext_s2  <= '0;
      r_ext_d   <= '0;
      r_fped_s1 <= 1'b0;
      r_fped_s2 <= 1'b0;
      r_fped_d  <= 1'b0;
      PULSE     <= '0;
      SYNCIP    <= 1'b0;
      CALLCT    <= 1'b0;
      CAL_GTRG  <= 1'b0;
      PEDESTAL  <= 1'b0;
      BUSY      <= 1'b0;
      SEQ_DONE  <= 1'b0;
      DROP_CNT  <= '0;
    end else begin
      r_ext_s1  <= TRIG_EXT;
      r_ext_s2  <= r_ext_s1;
      r_ext_d   <= r_ext_s2;
      r_fped_s1 <= FPED;
      r_fped_s2 <= r_fped_s1;
      r_fped_d  <= r_fped_s2;
      r_state   <= w_nstate;
      r_tcnt    <= w_ntcnt;
      r_shots   <= w_nshots;
      if (w_accept) begin
        r_mask  <= w_req_mask;
        r_width <= w_width_in;
        r_lct   <= LCT_DLY;
        r_l1a   <= L1A_DLY;
        r_gap   <= BURST_GAP;
        r_tend  <= w_tend;
      end
      PULSE    <= w_pulse;
      SYNCIP   <= w_sync;
      CALLCT   <= w_lct;
      CAL_GTRG <= w_l1a | RNDMGTRG;
      PEDESTAL <= PEDESTAL ^ w_fped_edge;
      BUSY     <= (r_state != IDLE) & ~w_abort;
      SEQ_DONE <= w_done;
      if (w_req && r_state != IDLE && DROP_CNT != 8'hFF)
        DROP_CNT <= DROP_CNT + 8'd1;
    end
  end

endmodule

// File: doc/calib_seq.md
# calib_seq

Parametrised calibration trigger sequencer, the successor to the fixed two-channel inject/pulse delay logic in the DMB JTAG control path. It accepts front-panel or CCB calibration requests on NCH channels and drives per-channel calibration pulses. It also emits a calibration LCT and a calibration L1A at programmable delays, counted in CLKCMS cycles rather than built from fixed SRL chains. New over the previous generation: burst mode (N shots with a programmable gap), configuration latched per sequence, drop counting, and a done strobe.

## Interface
Parameters:
- NCH, 2, number of calibration channels (inject, pulse, ...)
- DW, 12, width of delay and gap counters (max delay 2^DW-1 clocks)
- PW, 7, width of pulse-width field
- BW, 8, width of burst-count field

Ports (one clock; reset is asynchronous and active-low):
- CLKCMS  in  1  system clock (40 MHz)
- RST_N  in  1  asynchronous active-low reset
- EN  in  1  sequencer enable; low aborts and blocks requests
- TRIG_EXT  in  NCH  front-panel requests, level, asynchronous
- TRIG_CCB  in  NCH  CCB request strobes, synchronous, 1-cycle
- FPED  in  1  pedestal toggle request, level
- RNDMGTRG  in  1  random L1A, ORed into CAL_GTRG
- PLS_WIDTH  in  PW  pulse length in clocks (0 treated as 1)
- LCT_DLY  in  DW  clocks from pulse start to CALLCT
- L1A_DLY  in  DW  clocks from pulse start to CAL_GTRG
- BURST_CNT  in  BW  shots per sequence (0 treated as 1)
- BURST_GAP  in  DW  idle clocks between shots
- PULSE  out  NCH  per-channel calibration pulse
- SYNCIP  out  1  1-cycle scope sync at each shot start
- CALLCT  out  1  1-cycle calibration LCT
- CAL_GTRG  out  1  1-cycle calibration L1A
- PEDESTAL  out  1  pedestal mode flag
- BUSY  out  1  sequence in progress
- SEQ_DONE  out  1  1-cycle strobe at sequence end
- DROP_CNT  out  8  saturating count of rejected requests

## Operation
- TRIG_EXT passes through a 2-flop synchroniser, then leading-edge detection. A request is asserted in any cycle where any edge bit or any TRIG_CCB bit is high. The channel mask is the OR of both sources.
- FPED goes through the same synchroniser. Each leading edge toggles PEDESTAL.
- State machine states: IDLE, SHOT, GAP, DONE.
- IDLE: when a request is present, EN=1 and PEDESTAL=0, latch the mask, PLS_WIDTH, LCT_DLY, L1A_DLY, BURST_GAP and the shot count, clear tcnt, then go to SHOT. A request with EN=0 or PEDESTAL=1 is ignored and not counted.
- SHOT: tcnt increments each clock from 0.
  - PULSE[mask] is high while tcnt < width.
  - CALLCT is high when tcnt == LCT_DLY.
  - CAL_GTRG is high when tcnt == L1A_DLY.
  - The shot ends when tcnt == max(width-1, LCT_DLY, L1A_DLY).
  - At shot end, if shots remain, go to GAP. Otherwise go to DONE.
- GAP: wait BURST_GAP clocks, then enter SHOT with tcnt=0. If BURST_GAP=0, the next shot starts the clock after shot end.
- DONE: assert SEQ_DONE for one cycle, then return to IDLE.
- A request arriving while not in IDLE increments DROP_CNT, which saturates at 255. Two simultaneous requests in one cycle count as one.
- An EN falling edge or PEDESTAL rising edge during any non-IDLE state aborts the sequence. The next clock is IDLE with all pulse outputs low; SEQ_DONE is not asserted.
- CAL_GTRG = registered (sequencer L1A | RNDMGTRG). RNDMGTRG is accepted in any state.
- Configuration inputs changing mid-sequence have no effect until the next accepted request.

## Timing
- Reset values: every output is 0. State is IDLE, tcnt=0, DROP_CNT=0, PEDESTAL=0.
- All outputs are registered.
- TRIG_CCB high at clock edge k: PULSE rises after edge k+1. SYNCIP is high for that same single cycle.
- TRIG_EXT rises before edge k: the request is seen at edge k+2, so PULSE rises after edge k+3.
- CALLCT is high in the cycle LCT_DLY clocks after PULSE rises; CAL_GTRG likewise at L1A_DLY.
- A delay of 0 makes the output coincide with the first PULSE cycle.
- RNDMGTRG appears on CAL_GTRG one clock after sampling.
- BUSY is high from the first SHOT cycle through the DONE cycle inclusive.
- Shot period = max(width, LCT_DLY+1, L1A_DLY+1) + BURST_GAP clocks.
- A request sampled in the DONE cycle is dropped. A request sampled in the first IDLE cycle is accepted.

## Test plan
- Single CCB shot: mask 01, PLS_WIDTH=4, LCT_DLY=19, L1A_DLY=122, BURST_CNT=1, TRIG_CCB[0] at edge 10 -> PULSE[0] high for cycles 11-14, CALLCT at 30, CAL_GTRG at 133, SEQ_DONE at 134, BUSY cycles 11-134.
- Burst: BURST_CNT=3, BURST_GAP=5, PLS_WIDTH=2, LCT_DLY=3, L1A_DLY=6 -> three shots at a 12-clock period, exactly 3 CALLCT and 3 CAL_GTRG, one SEQ_DONE.
- Drops: 4 CCB requests during BUSY, including one same-cycle pair on both channels -> DROP_CNT=3. Then 300 more -> DROP_CNT holds at 255.
- Pedestal abort: FPED edge mid-SHOT -> PEDESTAL=1 two clocks later, next clock PULSE=0, BUSY=0, no SEQ_DONE. Further requests are ignored and DROP_CNT is unchanged.
- Async reset asserted mid-GAP -> all outputs 0 immediately. After RST_N release, a new request gives the normal single-shot timing.
- RNDMGTRG pulse coinciding with a sequencer L1A -> exactly one CAL_GTRG cycle. RNDMGTRG in IDLE -> CAL_GTRG one clock later.
